crc_serial_tx: RTL and testbench
================================

# crc_serial_tx

Serial CRC frame transmitter: accepts a parallel data word over a valid/ready handshake, shifts it out MSB-first one bit per bit strobe, and appends the CRC computed on the fly by a serial LFSR. It is the transmit end of the serial CRC path, and its output stream is the framed input the serial CRC calculator/checker consumes. Default configuration is 8 data bits plus CRC-4 with polynomial x^4+x+1, so a frame is 12 bits: data followed by CRC.

## Interface

**Parameters**
- DATA_W, 8: payload bits per frame.
- CRC_W, 4: CRC width in bits.
- POLY, 4'b0011: generator polynomial with the implicit x^CRC_W term omitted (x^4+x+1).
- CRC_INIT, 4'b0000: LFSR value loaded at frame start.
- GAP_CYCLES, 1: idle clock cycles after the last CRC bit, before in_ready re-asserts. Legal range 0..15.

**Ports**
- clk, input, 1: single clock; all logic on posedge.
- rst, input, 1: reset, synchronous and active-high.
- in_valid, input, 1: in_data is valid.
- in_ready, output, 1: block can accept a word.
- in_data, input, DATA_W: payload word; bit DATA_W-1 is sent first.
- bit_en, input, 1: bit strobe; the current serial bit is consumed and the stream advances only on cycles where bit_en=1.
- ser_out, output, 1: serial bit.
- ser_valid, output, 1: ser_out carries a frame bit.
- ser_sof, output, 1: ser_out is the first data bit.
- ser_crc, output, 1: ser_out is a CRC bit.
- ser_eof, output, 1: ser_out is the last CRC bit.
- crc_value, output, CRC_W: CRC of the current/last frame, valid from the first CRC bit until the next frame is accepted.

## Operation

**States**
- IDLE: in_ready=1 (and rst=0). On in_valid&in_ready:
  - load the shift register with in_data;
  - load the LFSR with CRC_INIT;
  - clear the bit counter;
  - go to DATA.
- DATA: ser_out = shreg[DATA_W-1], ser_valid=1. On each bit_en:
  - LFSR update: fb = lfsr[CRC_W-1] ^ ser_out; lfsr = {lfsr[CRC_W-2:0],0} ^ (fb ? POLY : 0);
  - shreg shifts left and the counter increments;
  - after the DATA_W-th strobe, go to CRC.
- CRC: ser_out = lfsr[CRC_W-1], ser_crc=1, ser_valid=1. On each bit_en the LFSR shifts left with zero fill and no feedback. After the CRC_W-th strobe, go to GAP, or to IDLE if GAP_CYCLES=0.
- GAP: counts GAP_CYCLES clocks, independent of bit_en, then goes to IDLE.

**Flags and data rules**
- ser_sof=1 only on counter 0 in DATA.
- ser_eof=1 only on the last CRC bit.
- crc_value is captured on entry to CRC.
- in_data is sampled only at the handshake edge; later changes are ignored.
- in_valid in non-IDLE states is ignored.

**Boundaries and reset**
- bit_en low holds all outputs stable, however long it stays low.
- bit_en is ignored in IDLE and GAP.
- Counter wrap: the counter never exceeds max(DATA_W, CRC_W)-1 and is cleared on every state change.
- rst high at any cycle: next cycle state=IDLE, the frame in progress is abandoned (no partial CRC is sent), and the LFSR is reloaded with CRC_INIT.
- Reset values: ser_out=0, ser_valid=0, ser_sof=0, ser_crc=0, ser_eof=0, crc_value=0. in_ready=0 while rst=1, then 1 on the first cycle rst=0.

## Timing

- Handshake: transfer on the posedge where in_valid=1 and in_ready=1. in_ready is low from the next cycle until IDLE is re-entered.
- Latency: the first data bit (ser_sof) is on ser_out the cycle after the handshake edge.
- With bit_en tied high, a frame is DATA_W+CRC_W cycles of ser_valid, then GAP_CYCLES idle cycles, then one IDLE cycle. Back-to-back period (in_valid held high) is 14 cycles for the default configuration.
- Outputs are registered or decoded from registered state only; there are no combinational paths from inputs to ser_*.
- in_ready depends only on state and rst.

## Test plan

- **Basic frame.** Accept 8'hA6, bit_en=1 → serial stream 1010_0110_1110, crc_value=4'hE. ser_sof on bit 1, ser_crc on bits 9-12, ser_eof on bit 12.
- **Second pattern.** Accept 8'hA2 → stream 1010_0010_0010, crc_value=4'h2. Accept 8'hFF → stream 1111_1111_0100. Accept 8'h00 → 12 zeros, crc_value=0.
- **Throttled strobe.** Accept 8'hA6 with bit_en pulsed every 3rd cycle → same 12-bit sequence, each bit held 3 cycles. in_data changed after the handshake has no effect.
- **Back-to-back.** in_valid held high with words A6 then A2, GAP_CYCLES=1 → second ser_sof exactly 14 cycles after the first. With GAP_CYCLES=0 → 13 cycles.
- **Reset mid-frame.** Assert rst during CRC bit 2 → next cycle all ser_* are 0 and state is IDLE. A new 8'hA6 frame after release produces the correct 1110 CRC.
- **Handshake stall.** in_valid=0 for 20 cycles → in_ready stays 1 and ser_valid stays 0. in_valid pulsed while a frame is in flight → ignored, no second frame.

Source files
------------

// File: rtl/crc_serial_tx_if.sv
// rtl/crc_serial_tx_if.sv - parallel word handshake into the serial CRC transmitter
//
// Purpose: carries one payload word from a producer (master) to crc_serial_tx
// (slave) using a valid/ready handshake. A transfer happens on the clock edge
// where in_valid and in_ready are both high.
//
// Signals:
//   in_valid  master -> slave   in_data holds a word to send
//   in_ready  slave  -> master  transmitter can accept a word
//   in_data   master -> slave   payload word, MSB transmitted first

interface crc_serial_tx_if #(
   parameter int DATA_W = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/crc_serial_tx.sv
// rtl/crc_serial_tx.sv - serial frame transmitter appending an on-the-fly LFSR CRC
//
// Purpose: accepts a parallel word, shifts it out MSB-first one bit per bit_en
// strobe, then shifts out the CRC_W-bit CRC of those bits, then idles for
// GAP_CYCLES clocks before accepting the next word.
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   bus        crc_serial_tx_if slave: in_valid / in_ready / in_data
//   bit_en     bit strobe; the serial stream only advances when high
//   ser_out    serial bit
//   ser_valid  ser_out carries a frame bit
//   ser_sof    ser_out is the first data bit
//   ser_crc    ser_out is a CRC bit
//   ser_eof    ser_out is the last CRC bit
//   crc_value  CRC of the current/last frame, updated on entry to the CRC bits

module crc_serial_tx #(
   parameter int               DATA_W     = 8,
   parameter int               CRC_W      = 4,
   parameter logic [CRC_W-1:0] POLY       = 4'b0011,
   parameter logic [CRC_W-1:0] CRC_INIT   = 4'b0000,
   parameter int               GAP_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   crc_serial_tx_if.slave    bus,
   input  logic              bit_en,
   output logic              ser_out,
   output logic              ser_valid,
   output logic              ser_sof,
   output logic              ser_crc,
   output logic              ser_eof,
   output logic [CRC_W-1:0]  crc_value
);

   localparam int MAX_W = (DATA_W > CRC_W) ? DATA_W : CRC_W;
   localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(CRC_W - 1);
   // GAP is never entered when GAP_CYCLES is 0, so GAP_LAST only matters for >0.
   localparam logic [3:0]       GAP_LAST  = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_CRC,
      S_GAP
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [DATA_W-1:0] shreg;
   logic [CRC_W-1:0]  lfsr;
   logic [CRC_W-1:0]  lfsr_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [3:0]        gap_cnt;
   logic              ready;
   logic              accept;
   logic              fb;

   assign bus.in_ready = ready;

   always_comb begin
      state_nxt = state;
      ready     = (state == S_IDLE) && !rst;
      accept    = 1'b0;
      ser_out   = 1'b0;
      ser_valid = 1'b0;
      ser_sof   = 1'b0;
      ser_crc   = 1'b0;
      ser_eof   = 1'b0;
      fb        = 1'b0;
      lfsr_nxt  = lfsr;
      case (state)
         S_IDLE: begin
            accept = bus.in_valid && ready;
            if (accept) state_nxt = S_DATA;
         end
         S_DATA: begin
            ser_out   = shreg[DATA_W-1];
            ser_valid = 1'b1;
            ser_sof   = (cnt == '0);
            fb        = lfsr[CRC_W-1] ^ shreg[DATA_W-1];
            lfsr_nxt  = (lfsr << 1) ^ (fb ? POLY : '0);
            if (bit_en && (cnt == DATA_LAST)) state_nxt = S_CRC;
         end
         S_CRC: begin
            // The finished CRC is shifted out MSB-first; no feedback here.
            ser_out   = lfsr[CRC_W-1];
            ser_valid = 1'b1;
            ser_crc   = 1'b1;
            ser_eof   = (cnt == CRC_LAST);
            lfsr_nxt  = lfsr << 1;
            if (bit_en && (cnt == CRC_LAST))
               state_nxt = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
         end
         S_GAP: begin
            if (gap_cnt == GAP_LAST) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         shreg     <= '0;
         lfsr      <= CRC_INIT;
         cnt       <= '0;
         gap_cnt   <= '0;
         crc_value <= '0;
      end else begin
         state <= state_nxt;

         // Bit counter restarts at every state change so DATA and CRC share it.
         if (state_nxt != state) begin
            cnt     <= '0;
            gap_cnt <= '0;
         end else begin
            if (bit_en && ((state == S_DATA) || (state == S_CRC))) cnt <= cnt + 1'b1;
            if (state == S_GAP) gap_cnt <= gap_cnt + 1'b1;
         end

         case (state)
            S_IDLE: begin
               if (accept) begin
                  shreg <= bus.in_data;
                  lfsr  <= CRC_INIT;
               end
            end
            S_DATA: begin
               if (bit_en) begin
                  shreg <= shreg << 1;
                  lfsr  <= lfsr_nxt;
                  if (cnt == DATA_LAST) crc_value <= lfsr_nxt;
               end
            end
            S_CRC: begin
               if (bit_en) lfsr <= lfsr_nxt;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_crc_serial_tx.sv
// tb/tb_crc_serial_tx.sv - directed self-checking bench for crc_serial_tx

module tb_crc_serial_tx;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic bit_en = 1'b0;

   always #5 clk = ~clk;

   crc_serial_tx_if #(.DATA_W(8)) bus  ();
   crc_serial_tx_if #(.DATA_W(8)) bus0 ();

   logic       ser_out, ser_valid, ser_sof, ser_crc, ser_eof;
   logic [3:0] crc_value;
   logic       ser_out0, ser_valid0, ser_sof0, ser_crc0, ser_eof0;
   logic [3:0] crc_value0;

   crc_serial_tx #(
      .DATA_W(8), .CRC_W(4), .POLY(4'b0011), .CRC_INIT(4'b0000), .GAP_CYCLES(1)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus), .bit_en(bit_en),
      .ser_out(ser_out), .ser_valid(ser_valid), .ser_sof(ser_sof),
      .ser_crc(ser_crc), .ser_eof(ser_eof), .crc_value(crc_value)
   );

   crc_serial_tx #(
      .DATA_W(8), .CRC_W(4), .POLY(4'b0011), .CRC_INIT(4'b0000), .GAP_CYCLES(0)
   ) dut0 (
      .clk(clk), .rst(rst), .bus(bus0), .bit_en(bit_en),
      .ser_out(ser_out0), .ser_valid(ser_valid0), .ser_sof(ser_sof0),
      .ser_crc(ser_crc0), .ser_eof(ser_eof0), .crc_value(crc_value0)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_idle(input string tag);
      int w = 0;
      while (!bus.in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk(tag, 32'(bus.in_ready), 32'd1);
   endtask

   // Sends one word on dut and records the bits consumed by bit_en strobes.
   task automatic run_frame(input logic [7:0] word, input int period, input bit poke,
                            output logic [11:0] stream, output int vcnt,
                            output logic [11:0] sof_m, output logic [11:0] crc_m,
                            output logic [11:0] eof_m);
      int c = 0;
      int n = 0;
      stream = '0; sof_m = '0; crc_m = '0; eof_m = '0; vcnt = 0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = word;
      chk("hs_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (period > 1) bus.in_data = 8'h00;
      if (poke) bus.in_data = 8'hFF;
      while (n < 12 && c < 200) begin
         bit_en = ((c % period) == period - 1);
         if (poke) bus.in_valid = (n == 5);
         if (ser_valid) vcnt++;
         if (ser_valid && bit_en) begin
            stream = {stream[10:0], ser_out};
            sof_m  = {sof_m[10:0], ser_sof};
            crc_m  = {crc_m[10:0], ser_crc};
            eof_m  = {eof_m[10:0], ser_eof};
            n++;
         end
         c++;
         @(negedge clk);
      end
      bit_en = 1'b0;
      bus.in_valid = 1'b0;
      chk("frame_bits", 32'(n), 32'd12);
   endtask

   // Back-to-back words A6 then A2 with in_valid held; returns sof spacing.
   task automatic b2b(input bit sel, input int exp_gap, input string tag);
      int c = 0;
      int first = -1;
      int second = -1;
      int w = 0;
      logic sof;
      @(negedge clk);
      bit_en = 1'b1;
      if (sel) begin bus0.in_valid = 1'b1; bus0.in_data = 8'hA6; end
      else     begin bus.in_valid  = 1'b1; bus.in_data  = 8'hA6; end
      while (second < 0 && c < 100) begin
         @(negedge clk);
         c++;
         sof = sel ? ser_sof0 : ser_sof;
         if (sof) begin
            if (first < 0) begin
               first = c;
               if (sel) bus0.in_data = 8'hA2; else bus.in_data = 8'hA2;
            end else begin
               second = c;
            end
         end
      end
      bus.in_valid = 1'b0;
      bus0.in_valid = 1'b0;
      chk(tag, 32'(second - first), 32'(exp_gap));
      while (!(sel ? bus0.in_ready : bus.in_ready) && w < 50) begin
         @(negedge clk);
         w++;
      end
      bit_en = 1'b0;
      chk({tag, "_crc"}, 32'(sel ? crc_value0 : crc_value), 32'h2);
   endtask

   logic [11:0] stream, sof_m, crc_m, eof_m;
   int vcnt;
   int bad;
   int k;
   int c;

   initial begin
      bus.in_valid = 1'b0;  bus.in_data = 8'h00;
      bus0.in_valid = 1'b0; bus0.in_data = 8'h00;

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_ser", 32'({ser_out, ser_valid, ser_sof, ser_crc, ser_eof}), 32'd0);
      chk("rst_crc", 32'(crc_value), 32'd0);
      rst = 1'b0;
      #1;
      chk("rel_ready", 32'(bus.in_ready), 32'd1);

      // Basic frame A6
      run_frame(8'hA6, 1, 1'b0, stream, vcnt, sof_m, crc_m, eof_m);
      chk("a6_stream", 32'(stream), 32'hA6E);
      chk("a6_vcnt", 32'(vcnt), 32'd12);
      chk("a6_sof", 32'(sof_m), 32'h800);
      chk("a6_crcflag", 32'(crc_m), 32'h00F);
      chk("a6_eof", 32'(eof_m), 32'h001);
      chk("a6_crcval", 32'(crc_value), 32'hE);
      wait_idle("a6_idle");

      // Other patterns
      run_frame(8'hA2, 1, 1'b0, stream, vcnt, sof_m, crc_m, eof_m);
      chk("a2_stream", 32'(stream), 32'hA22);
      chk("a2_crcval", 32'(crc_value), 32'h2);
      wait_idle("a2_idle");
      run_frame(8'hFF, 1, 1'b0, stream, vcnt, sof_m, crc_m, eof_m);
      chk("ff_stream", 32'(stream), 32'hFF4);
      chk("ff_crcval", 32'(crc_value), 32'h4);
      wait_idle("ff_idle");
      run_frame(8'h00, 1, 1'b0, stream, vcnt, sof_m, crc_m, eof_m);
      chk("00_stream", 32'(stream), 32'h000);
      chk("00_crcval", 32'(crc_value), 32'h0);
      wait_idle("00_idle");

      // Throttled strobe, in_data changed after handshake
      run_frame(8'hA6, 3, 1'b0, stream, vcnt, sof_m, crc_m, eof_m);
      chk("thr_stream", 32'(stream), 32'hA6E);
      chk("thr_vcnt", 32'(vcnt), 32'd36);
      chk("thr_crcval", 32'(crc_value), 32'hE);
      wait_idle("thr_idle");

      // Handshake stall
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (!bus.in_ready || ser_valid) bad++;
      end
      chk("stall", 32'(bad), 32'd0);

      // in_valid pulsed mid-frame is ignored
      run_frame(8'hA6, 1, 1'b1, stream, vcnt, sof_m, crc_m, eof_m);
      chk("poke_stream", 32'(stream), 32'hA6E);
      wait_idle("poke_idle");
      bad = 0;
      repeat (5) begin
         @(negedge clk);
         if (ser_valid) bad++;
      end
      chk("poke_noframe", 32'(bad), 32'd0);

      // Back-to-back
      b2b(1'b0, 14, "b2b_gap1");
      wait_idle("b2b_idle");
      b2b(1'b1, 13, "b2b_gap0");
      repeat (3) @(negedge clk);

      // Reset mid-frame during CRC bit 2
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data = 8'hA6;
      bit_en = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      k = 0;
      c = 0;
      while (k < 2 && c < 50) begin
         if (ser_crc) k++;
         if (k < 2) @(negedge clk);
         c++;
      end
      chk("mid_crcbit2", 32'(k), 32'd2);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_ser", 32'({ser_out, ser_valid, ser_sof, ser_crc, ser_eof}), 32'd0);
      chk("mid_rst_ready", 32'(bus.in_ready), 32'd0);
      chk("mid_rst_crc", 32'(crc_value), 32'd0);
      bit_en = 1'b0;
      rst = 1'b0;
      #1;
      chk("mid_rel_ready", 32'(bus.in_ready), 32'd1);
      run_frame(8'hA6, 1, 1'b0, stream, vcnt, sof_m, crc_m, eof_m);
      chk("mid_stream", 32'(stream), 32'hA6E);
      chk("mid_crcval", 32'(crc_value), 32'hE);
      wait_idle("mid_idle");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
